rv32_pipe_core: RTL and testbench

- Minimal 5-stage (IF/ID/EX/MEM/WB) RV32I-subset pipelined processor top.
- Has an on-chip instruction memory that is loaded word-by-word through a write port (we0/wr_addr0/wr_din0), and an on-chip data memory.
- resetpc gates execution: low = load/hold mode, high = run.
- Used as a standalone processor in simulation benches; architectural state is observed through debug outputs.

---
 rtl/rv32_pipe_pkg.sv | 90 +++++++++
 rtl/rv32_pipe_core_alu.sv | 35 +++
 rtl/rv32_pipe_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_rv32_pipe_core.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rv32_pipe_pkg.sv
// Shared opcode/funct constants, ALU and immediate selectors, and pipeline
// register layouts for the rv32_pipe_core five-stage pipeline.
package rv32_pipe_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_type_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        use_imm;
    alu_op_t     alu_op;
    logic [2:0]  br_f3;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] data;
  } mem_wb_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_type_t t);
    case (t)
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_U:   return {ins[31:12], 12'b0};
      default: return {{20{ins[31]}}, ins[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/rv32_pipe_core_alu.sv
// 32-bit ALU for the EX stage; also supplies compare flags for branches.
module rv32_alu
  import rv32_pipe_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {31'b0, lt};
      ALU_SLTU: result = {31'b0, ltu};
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv32_pipe_core.sv
// Five-stage RV32I-subset pipeline with loadable instruction memory,
// data memory, EX-stage forwarding, load-use stall and EX branch resolution.
module rv32_pipe_core
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned DMEM_WORDS = 128,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        resetpc,
  input  logic        we0,
  input  logic [8:0]  wr_addr0,
  input  logic [31:0] wr_din0,
  output logic [31:0] dbg_pc,
  output logic        dbg_wb_we,
  output logic [4:0]  dbg_wb_rd,
  output logic [31:0] dbg_wb_data
);

  localparam int unsigned IW = $clog2(IMEM_WORDS);
  localparam int unsigned DW = $clog2(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];

  logic [31:0] pc;
  if_id_t      if_id;
  id_ex_t      id_ex;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;

  logic [31:0] imem_rd;
  assign imem_rd = imem[pc[IW+1:2]];

  always_ff @(posedge clk) begin
    if (we0) imem[wr_addr0[IW+1:2]] <= wr_din0;
  end

  // ---------------- ID: decode ----------------
  id_ex_t      dec;
  logic [31:0] ins;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic        legal, use_rs1, use_rs2;
  imm_type_t   imm_t;

  assign ins = if_id.instr;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm_t   = IMM_I;
    dec.alu_op = ALU_ADD;
    case (opc)
      OPC_OP: begin
        legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.reg_we = 1'b1;
        case ({f7, f3})
          {F7_BASE, F3_ADD}:  dec.alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}:  dec.alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}:  dec.alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}:  dec.alu_op = ALU_SLT;
          {F7_BASE, F3_SLTU}: dec.alu_op = ALU_SLTU;
          {F7_BASE, F3_XOR}:  dec.alu_op = ALU_XOR;
          {F7_BASE, F3_SR}:   dec.alu_op = ALU_SRL;
          {F7_ALT,  F3_SR}:   dec.alu_op = ALU_SRA;
          {F7_BASE, F3_OR}:   dec.alu_op = ALU_OR;
          {F7_BASE, F3_AND}:  dec.alu_op = ALU_AND;
          default:            legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal = 1'b1; use_rs1 = 1'b1; dec.reg_we = 1'b1; dec.use_imm = 1'b1;
        case (f3)
          F3_ADD:  dec.alu_op = ALU_ADD;
          F3_SLT:  dec.alu_op = ALU_SLT;
          F3_SLTU: dec.alu_op = ALU_SLTU;
          F3_XOR:  dec.alu_op = ALU_XOR;
          F3_OR:   dec.alu_op = ALU_OR;
          F3_AND:  dec.alu_op = ALU_AND;
          F3_SLL: begin
            dec.alu_op = ALU_SLL;
            legal = (f7 == F7_BASE);
          end
          F3_SR: begin
            dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal = (f3 == F3_WORD); use_rs1 = 1'b1;
        dec.reg_we = 1'b1; dec.mem_rd = 1'b1; dec.use_imm = 1'b1;
      end
      OPC_STORE: begin
        legal = (f3 == F3_WORD); use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.mem_wr = 1'b1; dec.use_imm = 1'b1; imm_t = IMM_S;
      end
      OPC_BRANCH: begin
        legal = (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.branch = 1'b1; imm_t = IMM_B;
      end
      OPC_JAL: begin
        legal = 1'b1; dec.reg_we = 1'b1; dec.jal = 1'b1; imm_t = IMM_J;
      end
      OPC_JALR: begin
        legal = (f3 == F3_ADD); use_rs1 = 1'b1;
        dec.reg_we = 1'b1; dec.jalr = 1'b1; dec.use_imm = 1'b1;
      end
      OPC_LUI: begin
        legal = 1'b1; dec.reg_we = 1'b1; dec.lui = 1'b1; dec.use_imm = 1'b1; imm_t = IMM_U;
      end
      default: legal = 1'b0;
    endcase

    // Unused source fields are zeroed so hazard/forwarding compares never match them.
    dec.valid  = 1'b1;
    dec.pc     = if_id.pc;
    dec.br_f3  = f3;
    dec.imm    = gen_imm(ins, imm_t);
    dec.reg_we = dec.reg_we && (ins[11:7] != 5'd0);
    dec.rd     = dec.reg_we ? ins[11:7] : 5'd0;
    dec.rs1    = use_rs1 ? ins[19:15] : 5'd0;
    dec.rs2    = use_rs2 ? ins[24:20] : 5'd0;

    if (dec.rs1 == 5'd0)                             dec.rs1_val = '0;
    else if (mem_wb.reg_we && mem_wb.rd == dec.rs1)  dec.rs1_val = mem_wb.data;
    else                                             dec.rs1_val = regs[dec.rs1];
    if (dec.rs2 == 5'd0)                             dec.rs2_val = '0;
    else if (mem_wb.reg_we && mem_wb.rd == dec.rs2)  dec.rs2_val = mem_wb.data;
    else                                             dec.rs2_val = regs[dec.rs2];

    if (!legal || !if_id.valid) dec = '0;
  end

  logic stall;
  assign stall = id_ex.mem_rd && id_ex.reg_we &&
                 ((id_ex.rd == dec.rs1) || (id_ex.rd == dec.rs2));

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res, target, ex_result;
  logic        eq, lt, ltu, br_taken, redirect;

  always_comb begin
    if (ex_mem.reg_we && ex_mem.rd == id_ex.rs1)       fwd_a = ex_mem.result;
    else if (mem_wb.reg_we && mem_wb.rd == id_ex.rs1)  fwd_a = mem_wb.data;
    else                                               fwd_a = id_ex.rs1_val;
    if (ex_mem.reg_we && ex_mem.rd == id_ex.rs2)       fwd_b = ex_mem.result;
    else if (mem_wb.reg_we && mem_wb.rd == id_ex.rs2)  fwd_b = mem_wb.data;
    else                                               fwd_b = id_ex.rs2_val;
  end

  assign op_a = id_ex.lui ? '0 : fwd_a;
  assign op_b = id_ex.use_imm ? id_ex.imm : fwd_b;

  rv32_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .alu_op (id_ex.alu_op),
    .result (alu_res),
    .eq     (eq),
    .lt     (lt),
    .ltu    (ltu)
  );

  always_comb begin
    case (id_ex.br_f3)
      F3_BEQ:  br_taken = eq;
      F3_BNE:  br_taken = !eq;
      F3_BLT:  br_taken = lt;
      F3_BGE:  br_taken = !lt;
      default: br_taken = 1'b0;
    endcase
  end

  assign redirect  = id_ex.valid && ((id_ex.branch && br_taken) || id_ex.jal || id_ex.jalr);
  assign target    = id_ex.jalr ? (alu_res & ~32'd1) : (id_ex.pc + id_ex.imm);
  assign ex_result = (id_ex.jal || id_ex.jalr) ? (id_ex.pc + 32'd4) : alu_res;

  // ---------------- MEM ----------------
  logic [31:0] dmem_rd;
  assign dmem_rd = dmem[ex_mem.result[DW+1:2]];

  always_ff @(posedge clk) begin
    if (ex_mem.mem_wr) dmem[ex_mem.result[DW+1:2]] <= ex_mem.store_data;
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      ex_mem.reg_we     <= id_ex.reg_we;
      ex_mem.mem_rd     <= id_ex.mem_rd;
      ex_mem.mem_wr     <= id_ex.mem_wr;
      ex_mem.rd         <= id_ex.rd;
      ex_mem.result     <= ex_result;
      ex_mem.store_data <= fwd_b;
      mem_wb.reg_we     <= ex_mem.reg_we;
      mem_wb.rd         <= ex_mem.rd;
      mem_wb.data       <= ex_mem.mem_rd ? dmem_rd : ex_mem.result;
      if (!resetpc) begin
        pc    <= RESET_PC;
        if_id <= '0;
        id_ex <= '0;
      end else if (redirect) begin
        pc    <= target;
        if_id <= '0;
        id_ex <= '0;
      end else if (stall) begin
        id_ex <= '0;
      end else begin
        pc          <= pc + 32'd4;
        if_id.valid <= 1'b1;
        if_id.pc    <= pc;
        if_id.instr <= imem_rd;
        id_ex       <= dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (mem_wb.reg_we) begin
      regs[mem_wb.rd] <= mem_wb.data;
    end
  end

  assign dbg_pc      = pc;
  assign dbg_wb_we   = mem_wb.reg_we;
  assign dbg_wb_rd   = mem_wb.rd;
  assign dbg_wb_data = mem_wb.data;

  logic unused_bits;
  assign unused_bits = ^{wr_addr0, pc, ex_mem.result, ltu};

endmodule

// File: tb/tb_rv32_pipe_core.sv
// Directed bench for rv32_pipe_core: latency, forwarding, load-use stall,
// taken branch, mid-run reset and resetpc hold with IMEM rewrite.
module tb_rv32_pipe_core;

  logic        clk = 1'b0;
  logic        reset, resetpc, we0;
  logic [8:0]  wr_addr0;
  logic [31:0] wr_din0;
  logic [31:0] dbg_pc;
  logic        dbg_wb_we;
  logic [4:0]  dbg_wb_rd;
  logic [31:0] dbg_wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32_pipe_core #(.IMEM_WORDS(128), .DMEM_WORDS(128), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .resetpc     (resetpc),
    .we0         (we0),
    .wr_addr0    (wr_addr0),
    .wr_din0     (wr_din0),
    .dbg_pc      (dbg_pc),
    .dbg_wb_we   (dbg_wb_we),
    .dbg_wb_rd   (dbg_wb_rd),
    .dbg_wb_data (dbg_wb_data)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
    chk({tag, "_we"}, {31'b0, dbg_wb_we}, {31'b0, we});
    if (we) begin
      chk({tag, "_rd"}, {27'b0, dbg_wb_rd}, {27'b0, rd});
      chk({tag, "_data"}, dbg_wb_data, data);
    end
  endtask

  // Loads four words plus four NOPs with resetpc low, then releases resetpc:
  // on return the core is in run cycle 0 with PC = 0.
  task automatic load_prog(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] words [4];
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    resetpc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      we0      = 1'b1;
      wr_addr0 = 9'(i * 4);
      wr_din0  = (i < 4) ? words[i] : NOP;
      step(1);
    end
    we0     = 1'b0;
    resetpc = 1'b1;
  endtask

  initial begin
    reset = 1'b1; resetpc = 1'b0; we0 = 1'b0; wr_addr0 = '0; wr_din0 = '0;
    step(2);
    chk("rst_pc", dbg_pc, 32'h0);
    chk("rst_we", {31'b0, dbg_wb_we}, 32'h0);
    chk("rst_rd", {27'b0, dbg_wb_rd}, 32'h0);
    chk("rst_data", dbg_wb_data, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 128; i++) begin
      we0 = 1'b1; wr_addr0 = 9'(i * 4); wr_din0 = NOP;
      step(1);
    end
    we0 = 1'b0;

    // Program A: forwarding from both EX/MEM and MEM/WB
    load_prog(addi(5'd1, 5'd0, 12'd5), addi(5'd2, 5'd0, 12'd7), add(5'd3, 5'd1, 5'd2), NOP);
    chk("a_pc0", dbg_pc, 32'h0);
    step(1); chk("a_pc1", dbg_pc, 32'h4);
    step(2); chk_wb("a_c3", 1'b0, 5'd0, 32'h0);
    step(1); chk_wb("a_x1", 1'b1, 5'd1, 32'd5); chk("a_pc4", dbg_pc, 32'd16);
    step(1); chk_wb("a_x2", 1'b1, 5'd2, 32'd7);
    step(1); chk_wb("a_x3", 1'b1, 5'd3, 32'd12);

    // Mid-run reset, then identical re-execution
    reset = 1'b1;
    step(1);
    chk("mr_pc", dbg_pc, 32'h0);
    chk("mr_we", {31'b0, dbg_wb_we}, 32'h0);
    chk("mr_rd", {27'b0, dbg_wb_rd}, 32'h0);
    chk("mr_data", dbg_wb_data, 32'h0);
    reset = 1'b0;
    step(3); chk_wb("mr_c3", 1'b0, 5'd0, 32'h0);
    step(1); chk_wb("mr_x1", 1'b1, 5'd1, 32'd5);
    step(1); chk_wb("mr_x2", 1'b1, 5'd2, 32'd7);
    step(1); chk_wb("mr_x3", 1'b1, 5'd3, 32'd12);

    // resetpc low while rewriting IMEM[0]
    resetpc = 1'b0; we0 = 1'b1; wr_addr0 = 9'h0; wr_din0 = addi(5'd1, 5'd0, 12'd9);
    step(1); chk("hp_pc0", dbg_pc, 32'h0);
    we0 = 1'b0;
    step(1); chk("hp_pc1", dbg_pc, 32'h0);
    resetpc = 1'b1;
    step(4); chk_wb("hp_x1", 1'b1, 5'd1, 32'd9);
    step(1); chk_wb("hp_x2", 1'b1, 5'd2, 32'd7);
    step(1); chk_wb("hp_x3", 1'b1, 5'd3, 32'd16);

    // Program B: back-to-back dependency chain, no stall
    load_prog(addi(5'd1, 5'd0, 12'd1), addi(5'd1, 5'd1, 12'd1),
              addi(5'd1, 5'd1, 12'd1), addi(5'd1, 5'd1, 12'd1));
    step(3); chk("b_pc3", dbg_pc, 32'd12);
    step(1); chk_wb("b_1", 1'b1, 5'd1, 32'd1);
    step(1); chk_wb("b_2", 1'b1, 5'd1, 32'd2);
    step(1); chk_wb("b_3", 1'b1, 5'd1, 32'd3);
    step(1); chk_wb("b_4", 1'b1, 5'd1, 32'd4);

    // Program C: store, load, load-use with one stall cycle
    load_prog(addi(5'd3, 5'd0, 12'd12), sw(5'd3, 5'd0, 12'd8),
              lw(5'd4, 5'd0, 12'd8), add(5'd5, 5'd4, 5'd4));
    step(4); chk_wb("c_x3", 1'b1, 5'd3, 32'd12); chk("c_pc4", dbg_pc, 32'd16);
    step(1); chk_wb("c_sw", 1'b0, 5'd0, 32'h0);   chk("c_pc5", dbg_pc, 32'd16);
    step(1); chk_wb("c_x4", 1'b1, 5'd4, 32'd12); chk("c_pc6", dbg_pc, 32'd20);
    step(1); chk_wb("c_bub", 1'b0, 5'd0, 32'h0);
    step(1); chk_wb("c_x5", 1'b1, 5'd5, 32'd24);

    // Program D: taken beq skips two instructions
    load_prog(beq(5'd0, 5'd0, 13'd12), addi(5'd1, 5'd0, 12'd1),
              addi(5'd2, 5'd0, 12'd2), addi(5'd3, 5'd0, 12'd3));
    step(2); chk("d_pc2", dbg_pc, 32'd8);
    step(1); chk("d_pc3", dbg_pc, 32'd12);
    step(1); chk_wb("d_beq", 1'b0, 5'd0, 32'h0); chk("d_pc4", dbg_pc, 32'd16);
    step(1); chk_wb("d_skip1", 1'b0, 5'd0, 32'h0);
    step(1); chk_wb("d_skip2", 1'b0, 5'd0, 32'h0);
    step(1); chk_wb("d_tgt", 1'b1, 5'd3, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
